// File: rtl/pe_link_pkg.sv
// Shared definitions for the PE tile north/south overlay link transmitter:
// link bit positions, destination codes, FSM states and small helpers.
package pe_link_pkg;

    localparam int NORTH_WIDTH    = 130;
    localparam int SOUTH_WIDTH    = 130;
    localparam int DATA_WIDTH     = 128;
    localparam int FIFO_ADDR_BITS = 2;
    localparam int CREDITS        = 4;
    localparam int CREDIT_BITS    = 3;

    localparam int LINK_VLD_BIT = 128;
    localparam int LINK_CRD_BIT = 129;

    localparam logic DEST_NORTH = 1'b0;
    localparam logic DEST_SOUTH = 1'b1;

    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(CREDITS);
    localparam logic [CREDIT_BITS-1:0] CREDIT_ONE = CREDIT_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } link_state_t;

    // One queued word: destination select above the payload.
    typedef struct packed {
        logic                  dest;
        logic [DATA_WIDTH-1:0] data;
    } fifo_word_t;

    // Builds an outgoing link word; everything is zero when no flit is sent.
    function automatic logic [NORTH_WIDTH-1:0] make_flit(input logic vld,
                                                         input logic [DATA_WIDTH-1:0] data);
        logic [NORTH_WIDTH-1:0] flit;
        flit = '0;
        if (vld) begin
            flit = {1'b0, 1'b1, data};
        end
        return flit;
    endfunction

    // Next credit count: a return and a send in the same cycle cancel out,
    // and a return arriving at the maximum is dropped.
    function automatic logic [CREDIT_BITS-1:0] credit_next(input logic [CREDIT_BITS-1:0] cnt,
                                                           input logic inc,
                                                           input logic dec);
        logic [CREDIT_BITS-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt != CREDIT_MAX)) begin
            nxt = cnt + CREDIT_ONE;
        end else if (dec && !inc) begin
            nxt = cnt - CREDIT_ONE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pe_link_fifo.sv
// Small synchronous FIFO holding words waiting for link credit.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pe_link_fifo #(
    parameter int WIDTH     = 129,
    parameter int ADDR_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] PTR_ONE = (ADDR_BITS+1)'(1);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                     (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign rdata   = mem[rd_ptr[ADDR_BITS-1:0]];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_BITS-1:0]] <= wdata;
        end
    end

    // Advance write and read pointers; reset empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/pe_link_tx_ns.sv
// Credit-based north/south link transmitter: queues local words and sends
// them strictly in order, each to the link named by its dest bit.
module pe_link_tx_ns
    import pe_link_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_dest,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [NORTH_WIDTH-1:0] in_from_north,
    input  logic [SOUTH_WIDTH-1:0] in_from_south,
    output logic [NORTH_WIDTH-1:0] out_to_north,
    output logic [SOUTH_WIDTH-1:0] out_to_south,
    output logic                   busy,
    output logic                   credit_err
);

    link_state_t            state;
    logic [CREDIT_BITS-1:0] credit_north;
    logic [CREDIT_BITS-1:0] credit_south;
    fifo_word_t             head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   head_credit_ok;
    logic                   send;
    logic                   send_north;
    logic                   send_south;
    logic                   pulse_north;
    logic                   pulse_south;
    logic                   overflow;
    logic                   flit_pending;
    logic                   link_in_unused;

    // Only the credit bit of the incoming links carries meaning here.
    assign link_in_unused = ^{in_from_north[LINK_CRD_BIT-1:0], in_from_south[LINK_CRD_BIT-1:0]};

    assign s_ready        = (state == RUN) && !fifo_full;
    assign push           = s_valid && s_ready;
    assign head_credit_ok = (head.dest == DEST_SOUTH) ? (credit_south != '0) : (credit_north != '0);
    assign send           = !fifo_empty && head_credit_ok;
    assign send_north     = send && (head.dest == DEST_NORTH);
    assign send_south     = send && (head.dest == DEST_SOUTH);
    assign pulse_north    = in_from_north[LINK_CRD_BIT];
    assign pulse_south    = in_from_south[LINK_CRD_BIT];
    assign overflow       = (pulse_north && !send_north && (credit_north == CREDIT_MAX)) ||
                            (pulse_south && !send_south && (credit_south == CREDIT_MAX));
    assign flit_pending   = out_to_north[LINK_VLD_BIT] || out_to_south[LINK_VLD_BIT];
    assign busy           = (state != IDLE) || !fifo_empty;

    pe_link_fifo #(
        .WIDTH     (DATA_WIDTH + 1),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (send),
        .wdata ({s_dest, s_data}),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Run/drain control; draining ends once the queue and output stage are clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (ap_start) state <= RUN;
                RUN:     if (!ap_start) state <= DRAIN;
                DRAIN: begin
                    if (ap_start) begin
                        state <= RUN;
                    end else if (fifo_empty && !flit_pending) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track downstream buffer space per direction and latch any credit overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_north <= CREDIT_MAX;
            credit_south <= CREDIT_MAX;
            credit_err   <= 1'b0;
        end else begin
            credit_north <= credit_next(credit_north, pulse_north, send_north);
            credit_south <= credit_next(credit_south, pulse_south, send_south);
            if (overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

    // Register the popped head onto its link for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_to_north <= '0;
            out_to_south <= '0;
        end else begin
            out_to_north <= make_flit(send_north, head.data);
            out_to_south <= make_flit(send_south, head.data);
        end
    end

endmodule

// File: tb/tb_pe_link_tx_ns.sv
// Testbench for pe_link_tx_ns: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a queue-based model.
module tb_pe_link_tx_ns;

    logic         clk = 1'b0;
    logic         reset;
    logic         ap_start;
    logic [127:0] s_data;
    logic         s_dest;
    logic         s_valid;
    logic         s_ready;
    logic [129:0] in_from_north;
    logic [129:0] in_from_south;
    logic [129:0] out_to_north;
    logic [129:0] out_to_south;
    logic         busy;
    logic         credit_err;

    int nchecks = 0;
    int nfail   = 0;

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_t;

    mode_t        m_mode;
    logic [128:0] mq[$];
    int           m_cred[2];
    logic         m_err;
    logic [129:0] m_north;
    logic [129:0] m_south;
    logic [128:0] seen[$];

    typedef struct {
        logic         ap;
        logic         v;
        logic         d;
        logic [127:0] data;
        logic         pn;
        logic         ps;
        logic         e_ready;
        logic         e_busy;
        logic         e_err;
        logic [129:0] e_north;
        logic [129:0] e_south;
    } vec_t;

    vec_t tbl[12];

    pe_link_tx_ns dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .s_data        (s_data),
        .s_dest        (s_dest),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .in_from_north (in_from_north),
        .in_from_south (in_from_south),
        .out_to_north  (out_to_north),
        .out_to_south  (out_to_south),
        .busy          (busy),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(logic ap, logic v, logic d, logic [127:0] data, logic pn, logic ps,
                                 logic er, logic eb, logic ee, logic [129:0] en, logic [129:0] es);
        vec_t r;
        r.ap = ap; r.v = v; r.d = d; r.data = data; r.pn = pn; r.ps = ps;
        r.e_ready = er; r.e_busy = eb; r.e_err = ee; r.e_north = en; r.e_south = es;
        return r;
    endfunction

    function automatic logic [127:0] w(int k);
        return {4{32'hA5C3_0000 + 32'(k)}};
    endfunction

    task automatic checkOutput(input string name, input logic [129:0] act, input logic [129:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode  = M_IDLE;
        mq.delete();
        m_cred[0] = 4;
        m_cred[1] = 4;
        m_err   = 1'b0;
        m_north = '0;
        m_south = '0;
    endtask

    // One clock of the link behaviour described in plain queue/integer terms.
    task automatic modelStep(input logic ap, input logic v, input logic d, input logic [127:0] data,
                             input logic pn, input logic ps);
        logic         ready;
        logic         snd;
        logic [128:0] hd;
        logic         pulse;
        logic         took;
        ready = (m_mode == M_RUN) && (mq.size() < 4);
        snd   = 1'b0;
        hd    = '0;
        if (mq.size() > 0) begin
            hd  = mq[0];
            snd = (m_cred[hd[128]] > 0);
        end
        case (m_mode)
            M_IDLE:  if (ap) m_mode = M_RUN;
            M_RUN:   if (!ap) m_mode = M_DRAIN;
            default: begin
                if (ap) m_mode = M_RUN;
                else if (mq.size() == 0 && !m_north[128] && !m_south[128]) m_mode = M_IDLE;
            end
        endcase
        for (int k = 0; k < 2; k++) begin
            pulse = (k == 0) ? pn : ps;
            took  = snd && (hd[128] == k[0]);
            if (pulse && !took) begin
                if (m_cred[k] == 4) m_err = 1'b1;
                else m_cred[k] = m_cred[k] + 1;
            end else if (took && !pulse) begin
                m_cred[k] = m_cred[k] - 1;
            end
        end
        m_north = (snd && !hd[128]) ? {2'b01, hd[127:0]} : '0;
        m_south = (snd &&  hd[128]) ? {2'b01, hd[127:0]} : '0;
        if (snd) void'(mq.pop_front());
        if (v && ready) mq.push_back({d, data});
    endtask

    task automatic compareModel();
        logic e_ready;
        logic e_busy;
        e_ready = (m_mode == M_RUN) && (mq.size() < 4);
        e_busy  = (m_mode != M_IDLE) || (mq.size() > 0);
        checkOutput("s_ready", 130'(s_ready), 130'(e_ready));
        checkOutput("busy", 130'(busy), 130'(e_busy));
        checkOutput("credit_err", 130'(credit_err), 130'(m_err));
        checkOutput("out_to_north", out_to_north, m_north);
        checkOutput("out_to_south", out_to_south, m_south);
    endtask

    // Drive one cycle of inputs (at negedge), clock it, then compare at the next negedge.
    task automatic applyStimulus(input logic ap, input logic v, input logic d, input logic [127:0] data,
                                 input logic pn, input logic ps);
        logic [159:0] r;
        ap_start = ap;
        s_valid  = v;
        s_dest   = d;
        s_data   = data;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        in_from_north = {pn, r[128:0]};
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        in_from_south = {ps, r[128:0]};
        modelStep(ap, v, d, data, pn, ps);
        @(posedge clk);
        @(negedge clk);
        compareModel();
        if (out_to_north[128]) seen.push_back({1'b0, out_to_north[127:0]});
        if (out_to_south[128]) seen.push_back({1'b1, out_to_south[127:0]});
    endtask

    task automatic idleCycles(input logic ap, input int n);
        for (int i = 0; i < n; i++) applyStimulus(ap, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic doReset();
        reset         = 1'b0;
        ap_start      = 1'b0;
        s_valid       = 1'b0;
        s_dest        = 1'b0;
        s_data        = '0;
        in_from_north = '0;
        in_from_south = '0;
        #2;
        checkOutput("rst_out_north", out_to_north, '0);
        checkOutput("rst_out_south", out_to_south, '0);
        checkOutput("rst_s_ready", 130'(s_ready), '0);
        checkOutput("rst_busy", 130'(busy), '0);
        checkOutput("rst_credit_err", 130'(credit_err), '0);
        modelReset();
        seen.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [127:0] a5;
        logic [127:0] b1;
        logic [127:0] c2;
        a5 = {4{32'hA5A5_A5A5}};
        b1 = {4{32'hB1B1_B1B1}};
        c2 = {4{32'hC2C2_C2C2}};
        tbl[0]  = mkv(1, 1, 0, a5, 0, 0, 1, 1, 0, '0, '0);
        tbl[1]  = mkv(1, 1, 0, a5, 0, 0, 1, 1, 0, '0, '0);
        tbl[2]  = mkv(1, 0, 0, '0, 0, 0, 1, 1, 0, {2'b01, a5}, '0);
        tbl[3]  = mkv(1, 1, 0, b1, 0, 0, 1, 1, 0, '0, '0);
        tbl[4]  = mkv(1, 0, 0, '0, 0, 0, 1, 1, 0, {2'b01, b1}, '0);
        tbl[5]  = mkv(1, 1, 0, c2, 0, 0, 1, 1, 0, '0, '0);
        tbl[6]  = mkv(1, 0, 0, '0, 1, 0, 1, 1, 0, {2'b01, c2}, '0);
        tbl[7]  = mkv(1, 0, 0, '0, 1, 0, 1, 1, 0, '0, '0);
        tbl[8]  = mkv(1, 0, 0, '0, 1, 0, 1, 1, 0, '0, '0);
        tbl[9]  = mkv(1, 0, 0, '0, 1, 0, 1, 1, 1, '0, '0);
        tbl[10] = mkv(1, 0, 0, '0, 0, 0, 1, 1, 1, '0, '0);
        tbl[11] = mkv(1, 0, 0, '0, 0, 1, 1, 1, 1, '0, '0);

        // T1/T4: single-cycle latency, cancelling send+return, overflow stickiness.
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].ap, tbl[i].v, tbl[i].d, tbl[i].data, tbl[i].pn, tbl[i].ps);
            checkOutput($sformatf("vec%0d_ready", i), 130'(s_ready), 130'(tbl[i].e_ready));
            checkOutput($sformatf("vec%0d_busy", i), 130'(busy), 130'(tbl[i].e_busy));
            checkOutput($sformatf("vec%0d_err", i), 130'(credit_err), 130'(tbl[i].e_err));
            checkOutput($sformatf("vec%0d_north", i), out_to_north, tbl[i].e_north);
            checkOutput($sformatf("vec%0d_south", i), out_to_south, tbl[i].e_south);
        end

        // T2: five south words against four credits; one return frees the fifth.
        doReset();
        idleCycles(1, 1);
        for (int k = 0; k < 5; k++) applyStimulus(1, 1, 1, w(k), 0, 0);
        idleCycles(1, 6);
        checkOutput("t2_sent4", 130'(seen.size()), 130'(4));
        if (seen.size() == 4) checkOutput("t2_last", 130'(seen[3]), 130'({1'b1, w(3)}));
        applyStimulus(1, 0, 0, '0, 0, 1);
        idleCycles(1, 1);
        checkOutput("t2_sent5", 130'(seen.size()), 130'(5));
        if (seen.size() == 5) checkOutput("t2_fifth", 130'(seen[4]), 130'({1'b1, w(4)}));

        // T3: head blocked on north credit holds back a south word behind it.
        doReset();
        idleCycles(1, 1);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, w(10 + k), 0, 0);
        idleCycles(1, 6);
        seen.delete();
        applyStimulus(1, 1, 0, w(20), 0, 0);
        applyStimulus(1, 1, 1, w(21), 0, 0);
        applyStimulus(1, 1, 0, w(22), 0, 0);
        idleCycles(1, 4);
        checkOutput("t3_blocked", 130'(seen.size()), 130'(0));
        applyStimulus(1, 0, 0, '0, 1, 0);
        idleCycles(1, 4);
        checkOutput("t3_two_sent", 130'(seen.size()), 130'(2));
        if (seen.size() == 2) begin
            checkOutput("t3_first", 130'(seen[0]), 130'({1'b0, w(20)}));
            checkOutput("t3_second", 130'(seen[1]), 130'({1'b1, w(21)}));
        end
        applyStimulus(1, 0, 0, '0, 1, 0);
        idleCycles(1, 3);
        checkOutput("t3_three_sent", 130'(seen.size()), 130'(3));
        if (seen.size() == 3) checkOutput("t3_third", 130'(seen[2]), 130'({1'b0, w(22)}));

        // T5: full FIFO, ap_start drops, queued words still drain and busy falls.
        doReset();
        idleCycles(1, 1);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, w(30 + k), 0, 0);
        idleCycles(1, 6);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, w(40 + k), 0, 0);
        checkOutput("t5_full_ready", 130'(s_ready), 130'(0));
        seen.delete();
        applyStimulus(0, 1, 0, w(44), 0, 0);
        checkOutput("t5_drop_ready", 130'(s_ready), 130'(0));
        checkOutput("t5_drop_busy", 130'(busy), 130'(1));
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, '0, 1, 0);
        for (int i = 0; i < 20 && busy; i++) idleCycles(0, 1);
        checkOutput("t5_busy_fell", 130'(busy), 130'(0));
        checkOutput("t5_drained", 130'(seen.size()), 130'(4));
        if (seen.size() == 4) checkOutput("t5_last", 130'(seen[3]), 130'({1'b0, w(43)}));

        // T6: reset with three words queued and credit_err set.
        doReset();
        idleCycles(1, 1);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, w(50 + k), 0, 0);
        idleCycles(1, 6);
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, w(60 + k), 0, 0);
        applyStimulus(1, 0, 0, '0, 0, 1);
        checkOutput("t6_err_before", 130'(credit_err), 130'(1));
        checkOutput("t6_busy_before", 130'(busy), 130'(1));
        doReset();
        idleCycles(1, 8);
        checkOutput("t6_no_stale", 130'(seen.size()), 130'(0));
        for (int k = 0; k < 5; k++) applyStimulus(1, 1, 0, w(70 + k), 0, 0);
        idleCycles(1, 6);
        checkOutput("t6_credits4", 130'(seen.size()), 130'(4));

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            logic ap;
            logic pn;
            logic ps;
            ap = ($urandom_range(0, 19) != 0);
            pn = (m_cred[0] < 4) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
            ps = (m_cred[1] < 4) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
            applyStimulus(ap, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          {$urandom(), $urandom(), $urandom(), $urandom()}, pn, ps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
